// File: rtl/reg_file_rw_sb.sv
// Register file with NRD combinational read ports, one protected write port,
// same-cycle write-to-read bypass and per-register pending (scoreboard) bits.
module reg_file_rw_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  skip,
  input  logic                  dirty,
  input  logic [ADDR_W-1:0]     wreg,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_reg,
  input  logic                  flush,
  input  logic [NRD*ADDR_W-1:0] rreg,
  input  logic [NRD-1:0]        rvalid,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  output logic                  stall
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS != 0);
  localparam bit R0Z   = (R0_ZERO != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_next;
  logic              we;

  assign we = wr_en & ~skip & ~dirty & ~(R0Z & (wreg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wreg] <= wd;
    end
  end

  // Write clears before reserve sets, so a same-cycle reserve of the
  // written register leaves it pending for the new producer.
  always_comb begin
    pend_next = pend;
    if (flush) begin
      pend_next = '0;
    end else begin
      if (we)     pend_next[wreg]    = 1'b0;
      if (rsv_en) pend_next[rsv_reg] = 1'b1;
    end
    if (R0Z) pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [ADDR_W-1:0] addr;
      logic              hit;
      addr = rreg[i*ADDR_W +: ADDR_W];
      hit  = BYP & we & (wreg == addr);
      if (R0Z && addr == '0) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rbusy[i]               = 1'b0;
      end else begin
        rd[i*DATA_W +: DATA_W] = hit ? wd : regs[addr];
        rbusy[i]               = pend[addr] & ~hit;
      end
    end
  end

  assign stall = |(rvalid & rbusy);

endmodule
